// File: rtl/countdown_sequencer.sv
// Command sequencer for a 4-bit down-counter.
// Takes a load request over valid/ready, then drives the counter pins:
// one latch pulse, then dec until the counter reports zero.
// A run that never reaches zero parks in an error state until the host clears it.
module countdown_sequencer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  input  logic [WIDTH-1:0] req_value_i,
  output logic             req_ready_o,
  input  logic             abort_i,
  input  logic             err_clr_i,
  input  logic             zero_i,
  output logic [WIDTH-1:0] in_o,
  output logic             latch_o,
  output logic             dec_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] done_count_o
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StRun,
    StDone,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [WIDTH-1:0]  in_q, in_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              latch_q, done_q, err_q, busy_q;

  // Next-state logic: abort takes priority over zero and timeout in active states.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    in_d    = in_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          in_d    = req_value_i;
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d = abort_i ? StIdle : StSettle;
      end
      StSettle: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (zero_i) begin
          state_d = StDone;
        end else begin
          state_d = StRun;
          timer_d = '0;
        end
      end
      StRun: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (zero_i) begin
          state_d = StDone;
        end else if (timer_q == TimerMax) begin
          state_d = StError;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDone: begin
        count_d = count_q + 1'b1;
        state_d = StIdle;
      end
      StError: begin
        if (err_clr_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      timer_q <= '0;
      in_q    <= '0;
      count_q <= '0;
      latch_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      in_q    <= in_d;
      count_q <= count_d;
      latch_q <= (state_d == StLoad);
      done_q  <= (state_d == StDone);
      err_q   <= (state_d == StError);
      busy_q  <= (state_d != StIdle);
    end
  end

  // dec is the only combinational output: it must drop the moment the counter hits zero.
  always_comb begin
    dec_o = (state_q == StRun) && !zero_i;
  end

  assign req_ready_o  = ~busy_q;
  assign in_o         = in_q;
  assign latch_o      = latch_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign done_count_o = count_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: a behavioural 4-bit counter closes the loop, and each job's
// cycle-by-cycle outputs are predicted from the start value with plain arithmetic.
module tb_countdown_sequencer;

  localparam int unsigned W  = 4;
  localparam int unsigned TO = 64;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, abort, err_clr, zero;
  logic [W-1:0]  req_value, in_o;
  logic          latch, dec, busy, done, err;
  logic [CW-1:0] done_count;

  logic [W-1:0]  cnt_q = '0;
  logic          tie_zero_low;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  countdown_sequencer #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_value_i (req_value),
    .req_ready_o (req_ready),
    .abort_i     (abort),
    .err_clr_i   (err_clr),
    .zero_i      (zero),
    .in_o        (in_o),
    .latch_o     (latch),
    .dec_o       (dec),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .done_count_o(done_count)
  );

  always #5 clk = ~clk;

  // Counter being sequenced: loads on latch, decrements on dec.
  always @(posedge clk) begin
    if (latch) cnt_q <= in_o;
    else if (dec) cnt_q <= cnt_q - 1'b1;
  end
  assign zero = tie_zero_low ? 1'b0 : (cnt_q == '0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One job from an idle negedge. abort_at = edge index (after accept) carrying abort, 0 = none.
  // req_valid stays high with junk values while busy to prove it is held off.
  task automatic run_job(input int v, input int abort_at, output int decs, output int done_at);
    int done_j, last_j;
    logic active;
    logic [W+5:0] exp_v;
    done_j  = (v == 0) ? 2 : v + 3;
    last_j  = (abort_at > 0) ? abort_at : done_j + 1;
    decs    = 0;
    done_at = -1;
    check("ready_before_job", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_value = W'(v);
    for (int j = 0; j <= last_j; j++) begin
      @(negedge clk);
      active = (j <= done_j) && !(abort_at > 0 && j >= abort_at);
      exp_v = {W'(v),
               active && j == 0,
               active && v > 0 && j >= 2 && j <= v + 1,
               active && j == done_j,
               active,
               !active,
               1'b0};
      check($sformatf("job v=%0d cycle %0d {in,latch,dec,done,busy,ready,err}", v, j),
            {22'd0, in_o, latch, dec, done, busy, req_ready, err}, {22'd0, exp_v});
      if (dec) decs++;
      if (done) done_at = j;
      req_value = W'($urandom_range(15));
      req_valid = (j < last_j);
      abort     = (abort_at > 0) && (j + 1 == abort_at);
    end
    req_valid = 1'b0;
    abort     = 1'b0;
    if (abort_at == 0) exp_count = (exp_count + 1) % (1 << CW);
    check("done_count_after_job", {30'd0, done_count}, 32'(exp_count));
  endtask

  typedef struct {
    int value;
    int abort_at;
    int exp_decs;
    int exp_done_at;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int decs, done_at, v, dj, ab;
    int b2b_vals[5];
    bit found;

    vecs.push_back('{15, 0, 15, 18});  // full-scale load
    vecs.push_back('{0, 0, 0, 2});     // zero load: no dec at all
    vecs.push_back('{1, 0, 1, 4});
    vecs.push_back('{9, 5, 3, -1});    // abort mid-run
    vecs.push_back('{3, 6, 3, -1});    // abort on the same edge zero is seen
    vecs.push_back('{7, 1, 0, -1});    // abort in load
    vecs.push_back('{12, 2, 0, -1});   // abort in settle
    vecs.push_back('{0, 2, 0, -1});    // abort beats zero in settle

    rst_n = 1'b0; req_valid = 1'b0; req_value = '0; abort = 1'b0; err_clr = 1'b0;
    tie_zero_low = 1'b0;
    #1;
    check("reset_outputs", {22'd0, in_o, latch, dec, done, busy, err, done_count},
          32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {30'd0, busy, req_ready}, 32'd1);
    @(negedge clk);

    // Directed table
    foreach (vecs[i]) begin
      run_job(vecs[i].value, vecs[i].abort_at, decs, done_at);
      check($sformatf("vec%0d dec_cycles", i), 32'(decs), 32'(vecs[i].exp_decs));
      check($sformatf("vec%0d done_cycle", i), 32'(done_at), 32'(vecs[i].exp_done_at));
    end

    // Randomized jobs with occasional aborts and idle gaps
    for (int k = 0; k < 24; k++) begin
      v  = $urandom_range(15);
      dj = (v == 0) ? 2 : v + 3;
      ab = ($urandom_range(3) == 0) ? $urandom_range(dj, 1) : 0;
      run_job(v, ab, decs, done_at);
      repeat ($urandom_range(2)) begin
        @(negedge clk);
        check("idle_gap", {30'd0, busy, req_ready}, 32'd1);
      end
    end

    // Asynchronous reset in the middle of a run of 9
    req_valid = 1'b1;
    req_value = 4'd9;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_run_dec_before_reset", {31'd0, dec}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {22'd0, in_o, latch, dec, done, busy, err, done_count},
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    #1;
    check("ready_after_mid_reset", {30'd0, busy, req_ready}, 32'd1);
    @(negedge clk);
    run_job(2, 0, decs, done_at);

    // Timeout: zero never arrives
    tie_zero_low = 1'b1;
    req_valid = 1'b1;
    req_value = 4'd5;
    for (int j = 0; j <= 66; j++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (j == 65) check("timeout_last_run", {30'd0, dec, err}, 32'b10);
      if (j == 66) check("timeout_error", {28'd0, dec, err, busy, req_ready}, 32'b0110);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ignored_in_error", {30'd0, err, latch}, 32'b10);
    @(negedge clk);
    check("error_holds", {29'd0, err, dec, busy}, 32'b101);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("error_cleared", {29'd0, err, busy, req_ready}, 32'b001);
    check("error_no_count", {30'd0, done_count}, 32'(exp_count));
    tie_zero_low = 1'b0;
    @(negedge clk);

    // Back-to-back jobs with req_valid held high
    b2b_vals = '{2, 0, 1, 3, 0};
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req_value = W'(b2b_vals[k]);
      @(negedge clk);
      check($sformatf("b2b%0d accept_latch", k), {31'd0, latch}, 32'd1);
      found = 1'b0;
      for (int c = 0; c < 25 && !found; c++) begin
        @(negedge clk);
        check("b2b busy_ready_complement", {30'd0, busy, req_ready},
              {30'd0, 2'b10});
        if (done) found = 1'b1;
      end
      check($sformatf("b2b%0d done_seen", k), {31'd0, found}, 32'd1);
      @(negedge clk);
      exp_count = (exp_count + 1) % (1 << CW);
      check($sformatf("b2b%0d count", k), {30'd0, done_count}, 32'(exp_count));
      check($sformatf("b2b%0d idle_ready", k), {29'd0, busy, req_ready, latch}, 32'b010);
      if (k == 4) req_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_final_idle", {30'd0, busy, req_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
